// File: rtl/mem_arbiter_rr.sv
// Round-robin arbiter sharing one memory channel among NUM_CONSUMERS requesters.
// One transaction is in flight at a time; outputs are registered and cleared by reset_n.
module mem_arbiter_rr #(
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 16,
  parameter int NUM_CONSUMERS = 4,
  parameter int WRITE_ENABLE  = 1
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  input  logic [NUM_CONSUMERS-1:0]             consumer_read_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0]   consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]             consumer_read_ready,
  output logic [NUM_CONSUMERS*DATA_BITS-1:0]   consumer_read_data,
  input  logic [NUM_CONSUMERS-1:0]             consumer_write_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0]   consumer_write_address,
  input  logic [NUM_CONSUMERS*DATA_BITS-1:0]   consumer_write_data,
  output logic [NUM_CONSUMERS-1:0]             consumer_write_ready,
  output logic                                 mem_read_valid,
  output logic [ADDR_BITS-1:0]                 mem_read_address,
  input  logic                                 mem_read_ready,
  input  logic [DATA_BITS-1:0]                 mem_read_data,
  output logic                                 mem_write_valid,
  output logic [ADDR_BITS-1:0]                 mem_write_address,
  output logic [DATA_BITS-1:0]                 mem_write_data,
  input  logic                                 mem_write_ready,
  output logic                                 busy,
  output logic [$clog2(NUM_CONSUMERS)-1:0]     grant_id,
  output logic [2:0]                           state_dbg
);

  localparam int IDW = $clog2(NUM_CONSUMERS);

  // Handshake: a consumer raises valid and holds it (with stable address/data)
  // until it sees its ready; ready then stays high until that valid drops.
  // The memory side completes a request on the first cycle its ready is high
  // while the matching valid is high.
  typedef enum logic [2:0] {
    IDLE           = 3'd0,
    READ_WAITING   = 3'd1,
    WRITE_WAITING  = 3'd2,
    READ_RELAYING  = 3'd3,
    WRITE_RELAYING = 3'd4
  } state_t;

  state_t state, state_n;

  logic [IDW-1:0]                       rr_ptr, rr_ptr_n;
  logic [IDW-1:0]                       grant_n;
  logic [IDW-1:0]                       sel_idx, cand;
  logic                                 sel_found;
  logic [NUM_CONSUMERS-1:0]             eligible;
  logic                                 mrv_n, mwv_n;
  logic [ADDR_BITS-1:0]                 mra_n, mwa_n;
  logic [DATA_BITS-1:0]                 mwd_n;
  logic [NUM_CONSUMERS-1:0]             crr_n, cwr_n;
  logic [NUM_CONSUMERS*DATA_BITS-1:0]   crd_n;

  // Write requests are invisible to arbitration in a read-only build.
  assign eligible  = consumer_read_valid |
                     ({NUM_CONSUMERS{WRITE_ENABLE != 0}} & consumer_write_valid);
  assign busy      = (state != IDLE);
  assign state_dbg = state;

  // First eligible consumer at or after rr_ptr, wrapping modulo NUM_CONSUMERS.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int i = 0; i < NUM_CONSUMERS; i++) begin
      cand = rr_ptr + IDW'(i);
      if (!sel_found && eligible[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  always_comb begin
    state_n  = state;
    rr_ptr_n = rr_ptr;
    grant_n  = grant_id;
    mrv_n    = mem_read_valid;
    mra_n    = mem_read_address;
    mwv_n    = mem_write_valid;
    mwa_n    = mem_write_address;
    mwd_n    = mem_write_data;
    crr_n    = consumer_read_ready;
    cwr_n    = consumer_write_ready;
    crd_n    = consumer_read_data;
    case (state)
      IDLE: begin
        if (sel_found) begin
          grant_n  = sel_idx;
          rr_ptr_n = sel_idx + IDW'(1);
          if (consumer_read_valid[sel_idx]) begin
            mrv_n   = 1'b1;
            mra_n   = consumer_read_address[sel_idx*ADDR_BITS +: ADDR_BITS];
            state_n = READ_WAITING;
          end else begin
            mwv_n   = 1'b1;
            mwa_n   = consumer_write_address[sel_idx*ADDR_BITS +: ADDR_BITS];
            mwd_n   = consumer_write_data[sel_idx*DATA_BITS +: DATA_BITS];
            state_n = WRITE_WAITING;
          end
        end
      end
      READ_WAITING: begin
        if (mem_read_ready) begin
          mrv_n                                   = 1'b0;
          crr_n[grant_id]                         = 1'b1;
          crd_n[grant_id*DATA_BITS +: DATA_BITS]  = mem_read_data;
          state_n                                 = READ_RELAYING;
        end
      end
      WRITE_WAITING: begin
        if (mem_write_ready) begin
          mwv_n           = 1'b0;
          cwr_n[grant_id] = 1'b1;
          state_n         = WRITE_RELAYING;
        end
      end
      READ_RELAYING: begin
        if (!consumer_read_valid[grant_id]) begin
          crr_n[grant_id] = 1'b0;
          state_n         = IDLE;
        end
      end
      WRITE_RELAYING: begin
        if (!consumer_write_valid[grant_id]) begin
          cwr_n[grant_id] = 1'b0;
          state_n         = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state                <= IDLE;
      rr_ptr               <= '0;
      grant_id             <= '0;
      mem_read_valid       <= 1'b0;
      mem_read_address     <= '0;
      mem_write_valid      <= 1'b0;
      mem_write_address    <= '0;
      mem_write_data       <= '0;
      consumer_read_ready  <= '0;
      consumer_write_ready <= '0;
      consumer_read_data   <= '0;
    end else begin
      state                <= state_n;
      rr_ptr               <= rr_ptr_n;
      grant_id             <= grant_n;
      mem_read_valid       <= mrv_n;
      mem_read_address     <= mra_n;
      mem_write_valid      <= mwv_n;
      mem_write_address    <= mwa_n;
      mem_write_data       <= mwd_n;
      consumer_read_ready  <= crr_n;
      consumer_write_ready <= cwr_n;
      consumer_read_data   <= crd_n;
    end
  end

endmodule

// File: doc/mem_arbiter_rr.md
# mem_arbiter_rr

Round-robin arbiter that shares one memory channel among NUM_CONSUMERS requesters (LSU or fetcher ports) with fair, starvation-free access. It sits between the consumer-side valid/ready bus and a single memory channel. It serialises read and write transactions: only one transaction is outstanding at a time. The consumer-side and memory-side signalling matches the existing memory controller handshake.

## Interface
- ADDR_BITS, 8, address width per consumer
- DATA_BITS, 16, data width per consumer
- NUM_CONSUMERS, 4, requester count, ≥2, power of two
- WRITE_ENABLE, 1, 0 makes the block read-only (write requests ignored)

- clk  in  1  clock, all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- consumer_read_valid  in  NUM_CONSUMERS  per-consumer read request
- consumer_read_address  in  NUM_CONSUMERS*ADDR_BITS  flattened; consumer c at [c*ADDR_BITS +: ADDR_BITS]
- consumer_read_ready  out  NUM_CONSUMERS  read done, data valid
- consumer_read_data  out  NUM_CONSUMERS*DATA_BITS  flattened read data
- consumer_write_valid  in  NUM_CONSUMERS  per-consumer write request
- consumer_write_address  in  NUM_CONSUMERS*ADDR_BITS  flattened
- consumer_write_data  in  NUM_CONSUMERS*DATA_BITS  flattened
- consumer_write_ready  out  NUM_CONSUMERS  write done
- mem_read_valid / mem_read_address  out  1 / ADDR_BITS  memory read request
- mem_read_ready / mem_read_data  in  1 / DATA_BITS  memory read completion
- mem_write_valid / mem_write_address / mem_write_data  out  1 / ADDR_BITS / DATA_BITS
- mem_write_ready  in  1  memory write completion
- busy  out  1  state != IDLE
- grant_id  out  $clog2(NUM_CONSUMERS)  consumer currently served (held after completion)

## Operation
- States: IDLE, READ_WAITING, WRITE_WAITING, READ_RELAYING, WRITE_RELAYING.
- **IDLE, consumer selection:** scan consumers rr_ptr, rr_ptr+1, … (mod NUM_CONSUMERS). Select the first consumer c with read_valid[c], or with write_valid[c] when WRITE_ENABLE=1.
- **IDLE, read grant:** if read_valid[c], the read wins over a write from the same consumer. Set grant_id<=c, mem_read_valid<=1, latch the address, and go to READ_WAITING.
- **IDLE, write grant:** otherwise set mem_write_valid<=1, latch address and data, and go to WRITE_WAITING.
- **Pointer update:** on every grant, rr_ptr<=c+1 (wraps NUM_CONSUMERS-1 → 0).
- **READ_WAITING:** when mem_read_ready=1:
  - mem_read_valid<=0
  - consumer_read_ready[grant_id]<=1
  - slice grant_id of consumer_read_data <= mem_read_data; other slices unchanged
  - go to READ_RELAYING
- **WRITE_WAITING:** when mem_write_ready=1: mem_write_valid<=0, consumer_write_ready[grant_id]<=1, go to WRITE_RELAYING.
- **RELAYING:** when the granted consumer's matching valid is 0, drop its ready and go to IDLE.
- Memory ready inputs are ignored outside the corresponding WAITING state.
- Requests are never queued internally; an unserved consumer simply holds valid.
- **WRITE_ENABLE=0:** write_valid is ignored, consumer_write_ready and mem_write_valid stay 0, and mem_write_address/data stay 0.

## Timing
- **Reset (async, on reset_n=0):** every output goes to 0 (valids, readies, addresses, data, busy, grant_id); state=IDLE, rr_ptr=0. Reset mid-transaction abandons the transaction; no ready is ever issued for it.
- **Request to memory:** a request sampled at edge t gives mem_*_valid high after edge t (1 cycle).
- **Memory completion:** mem ready sampled at edge t+k gives mem valid low and consumer ready high after edge t+k. Best case is 2 cycles from request to consumer ready when memory is ready immediately.
- **Release:** the consumer drops valid; at the next edge ready drops and the state is IDLE.
- **New grant:** requires one IDLE cycle, so the minimum spacing between grants is 1 idle edge. Back-to-back service from consumers 0 → 1 has one IDLE edge between them.
- **Consumer drops valid during WAITING:** this is a protocol violation, but the memory access still completes. Ready pulses for exactly one cycle, then the block returns to IDLE.
- **Same consumer, read and write together:** the read is served first. The write then waits its next round-robin turn.
- **Mem ready held high continuously:** legal; each WAITING state lasts exactly one cycle.

## Test plan
- **Reset:** assert reset_n=0 mid READ_WAITING → all outputs 0 immediately (before the clock edge). After release, the first grant goes to consumer 0.
- **Single read:** consumer 2 reads addr 0x3C, memory returns 0xBEEF one cycle later → mem_read_address=0x3C, consumer_read_data[47:32]=0xBEEF, consumer_read_ready=4'b0100. Ready clears one edge after valid drops.
- **Fairness:** all 4 consumers issue reads continuously → grants in order 0,1,2,3,0. No consumer is granted twice before the others are served.
- **Mixed read and write on one consumer:** consumer 1 asserts both read and write, and consumer 3 writes 0x1234 to 0x10 → order is c1 read, c3 write (mem_write_data=0x1234, address 0x10), then c1 write.
- **Slow memory:** mem ready delayed by 5 cycles → mem valid stays high for 6 cycles and the address stays stable; no other consumer is granted.
- **WRITE_ENABLE=0:** writes from all consumers → mem_write_valid and consumer_write_ready never assert, and reads still complete normally.
